// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO behind uart_rx; never stalls the line and counts overrun and error drops.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DROP_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_parity_err,
  input  logic              in_frame_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_parity_err,
  output logic              out_frame_err,
  input  logic              flush,
  input  logic              clear_status,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  output logic [7:0]        drop_count,
  output logic [7:0]        err_count
);
  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              rdy, hs, pop, bad, store, drop, err;
  logic [7:0]        drop_nxt, err_nxt;
  assign in_ready  = rdy;
  assign count     = cnt;
  assign full      = cnt == (ADDR_W+1)'(DEPTH);
  assign empty     = cnt == '0;
  assign out_valid = !empty;
  assign {out_frame_err, out_parity_err, out_data} = mem[rd_ptr];
  always_comb begin
    hs       = in_valid & rdy & !flush;
    pop      = out_valid & out_ready & !flush;
    bad      = (DROP_ERR != 0) && (in_parity_err || in_frame_err);
    store    = hs & !bad & (!full | pop);
    drop     = hs & !bad & full & !pop;
    err      = hs & bad;
    // a same-cycle event beats clear_status, leaving the counter at 1
    drop_nxt = clear_status ? {7'd0, drop} : drop_count + {7'd0, drop && drop_count != 8'hff};
    err_nxt  = clear_status ? {7'd0, err} : err_count + {7'd0, err && err_count != 8'hff};
  end
  always_ff @(posedge clk)
    if (store) mem[wr_ptr] <= {in_frame_err, in_parity_err, in_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rdy        <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      rdy        <= 1'b1;
      overrun    <= drop | (overrun & !clear_status);
      drop_count <= drop_nxt;
      err_count  <= err_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + ADDR_W'(store);
        rd_ptr <= rd_ptr + ADDR_W'(pop);
        cnt    <= cnt + (ADDR_W+1)'(store) - (ADDR_W+1)'(pop);
      end
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of uart_rx. It consumes that block's rx_valid/rx_ready/rx_data/parity_err/frame_err stream and stores each byte with its two error flags in a power-of-two FIFO. It presents the stored bytes to the host side through a first-word-fall-through valid/ready interface. The UART line cannot be stalled, so the FIFO never back-pressures the receiver: a byte that arrives while the FIFO is full is dropped and flagged as overrun.

Parameters:
DEPTH, 16, number of entries; must be a power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
DROP_ERR, 0, 1 = bytes arriving with parity_err or frame_err set are discarded and counted in err_count instead of stored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  byte available from uart_rx (rx_valid)
in_ready  out  1  to uart_rx rx_ready
in_data  in  8  received byte
in_parity_err  in  1  parity error flag for in_data
in_frame_err  in  1  framing error flag for in_data
out_valid  out  1  head entry valid
out_ready  in  1  host consumes head entry
out_data  out  8  head byte
out_parity_err  out  1  head parity flag
out_frame_err  out  1  head framing flag
flush  in  1  synchronous FIFO clear
clear_status  in  1  clears overrun, drop_count and err_count
count  out  ADDR_W+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
overrun  out  1  sticky: at least one byte dropped because the FIFO was full
drop_count  out  8  bytes dropped due to full; saturates at 255
err_count  out  8  bytes discarded by DROP_ERR; saturates at 255; stays 0 when DROP_ERR=0

Behaviour:
- Reset (synchronous, highest priority): pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0, overrun = 0, drop_count = 0, err_count = 0, in_ready = 0. Storage contents are not reset.
- in_ready = 0 while reset is high and 1 on every cycle after it. A handshake (push attempt) occurs when in_valid & in_ready.
- Storage: register array of DEPTH x 10 bits holding {frame_err, parity_err, data}. Write pointer and read pointer are ADDR_W bits wide and wrap modulo DEPTH.
- Head path is FWFT:
  - out_valid = !empty.
  - out_data and both out flags are read combinationally at the read pointer.
  - A byte pushed at edge N is visible on out_valid/out_data after edge N, i.e. one cycle after the handshake.
- Pop occurs when out_valid & out_ready. out_ready while empty is ignored.
- Push decision, evaluated per handshake cycle:
  - If DROP_ERR=1 and (in_parity_err | in_frame_err): discard the byte and increment err_count. This check takes precedence over the full check.
  - Else if not full: store the byte.
  - Else if full and a pop happens in the same cycle: store the byte. Count stays at DEPTH and there is no overrun.
  - Else (full, no pop): discard the byte, set overrun, and increment drop_count.
- count: +1 on store without pop, -1 on pop without store, unchanged when both or neither occur.
- flush (priority below reset, above push/pop): pointers and count return to 0 on the next edge. A same-cycle push or pop is ignored; a same-cycle push is not counted as an overrun. flush does not clear status.
- clear_status zeroes overrun, drop_count and err_count. If a new drop or error event occurs in the same cycle, the event wins: the flag is set and the counter becomes 1.
- Counters saturate and hold at 255, never wrapping to 0.
- full, empty and count are registered-state-derived with no combinational path from in_valid or out_ready. out_* depend only on state.

Test Plan:
- Order and latency: DEPTH=4; after reset, push 0x55, 0xA3, 0x0F on consecutive cycles with out_ready=0 -> out_valid rises the cycle after the first push with out_data=0x55; count reaches 3; pops with out_ready=1 return 0x55, 0xA3, 0x0F, then empty=1.
- Overrun: DEPTH=4; push 0x01..0x06 with no pops -> count=4, full=1; bytes 0x05 and 0x06 dropped; overrun=1, drop_count=2; pops return 0x01..0x04. Then pulse clear_status -> overrun=0, drop_count=0.
- Full with simultaneous push and pop: FIFO holds 0x10..0x13 (full); in the same cycle push 0x14 and pop -> popped byte is 0x10, count stays 4, overrun=0; next four pops return 0x11..0x14, exercising pointer wrap.
- Error handling: with DROP_ERR=0, push 0xC3 with parity_err=1 -> stored, out_parity_err=1. With DROP_ERR=1, push 0xC3 with frame_err=1 then 0x3C clean -> err_count=1 and only 0x3C is delivered.
- Flush and reset: FIFO holds 3 bytes; assert flush together with in_valid (0x77) and out_ready -> next cycle count=0, empty=1, overrun unchanged, 0x77 never delivered. Then fill 2 bytes and assert reset mid-stream -> all outputs return to their reset values on the next edge.
- End-to-end: baud_gen, uart_tx, uart_rx and this block in a 50 MHz / 115200 chain with even parity; send 0x55, 0xAA, 0x00 -> the FIFO delivers the same three bytes in order with all error flags 0 and drop_count=0.
